// File: rtl/alu_issue_ctrl.sv
// Execute-stage sequencer for the S-Machine ALU: owns A/B and Z/N/C.
// Optional SETUP bypass is enabled by defining ALU_ISSUE_FASTISSUE_EN.
module alu_issue_ctrl #(
  parameter logic [3:0]  NOP_OPCODE    = 4'b0000,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] inst_in,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic        load_en,
  input  logic        load_sel,
  input  logic [15:0] load_data,
  output logic [15:0] alu_inst,
  output logic [15:0] alu_reg_A,
  output logic [15:0] alu_reg_B,
  output logic        alu_Z,
  output logic        alu_N,
  output logic        alu_C,
  input  logic [15:0] alu_reg_A_res,
  input  logic [15:0] alu_reg_B_res,
  input  logic        alu_Z_res,
  input  logic        alu_N_res,
  input  logic        alu_C_res,
  output logic [15:0] reg_A,
  output logic [15:0] reg_B,
  output logic        Z,
  output logic        N,
  output logic        C,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE, SETUP, ISSUE, CAPTURE
  } state_t;

  localparam logic [15:0] NOP_WORD = {NOP_OPCODE, 12'h000};
  localparam logic [3:0]  CNT_INIT = 4'(SETTLE_CYCLES - 1);

  state_t      state;
  logic [15:0] inst_q;
  logic [3:0]  cnt;
  logic [3:0]  op;
  logic        wr_a;
  logic        wr_b;
  logic        wr_f;
  logic        fast;

`ifdef ALU_ISSUE_FASTISSUE_EN
  logic loaded;
  assign fast = (inst_in != alu_inst) & ~loaded;
`else
  assign fast = 1'b0;
`endif

  assign inst_ready = (state == IDLE) & ~load_en;
  assign busy       = (state != IDLE);
  assign alu_reg_A  = reg_A;
  assign alu_reg_B  = reg_B;
  assign alu_Z      = Z;
  assign alu_N      = N;
  assign alu_C      = C;
  assign op         = inst_q[15:12];

  // Per-opcode writeback mask for the latched instruction
  always_comb begin
    wr_a = 1'b0;
    wr_b = 1'b0;
    wr_f = 1'b0;
    unique case (op)
      4'h2: begin
        wr_a = ~inst_q[11];
        wr_b = inst_q[11];
        wr_f = 1'b1;
      end
      4'h4, 4'h5, 4'h6, 4'h7,
      4'h8, 4'h9: begin
        wr_a = 1'b1;
        wr_f = 1'b1;
      end
      4'hA: begin
        wr_b = 1'b1;
        wr_f = 1'b1;
      end
      4'hB: begin
        wr_a = 1'b1;
        wr_b = 1'b1;
        wr_f = 1'b1;
      end
      4'hC, 4'hD, 4'hE: wr_f = 1'b1;
      default: ;
    endcase
  end

  // Issue sequencer, direct loads and architectural writeback
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      inst_q   <= 16'h0000;
      cnt      <= 4'd0;
      alu_inst <= NOP_WORD;
      reg_A    <= 16'h0000;
      reg_B    <= 16'h0000;
      Z        <= 1'b0;
      N        <= 1'b0;
      C        <= 1'b0;
      done     <= 1'b0;
`ifdef ALU_ISSUE_FASTISSUE_EN
      loaded   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (load_en) begin
            if (load_sel) reg_B <= load_data;
            else          reg_A <= load_data;
`ifdef ALU_ISSUE_FASTISSUE_EN
            loaded <= 1'b1;
`endif
          end else if (inst_valid) begin
            inst_q <= inst_in;
            if (fast) begin
              state    <= ISSUE;
              alu_inst <= inst_in;
              cnt      <= CNT_INIT;
            end else begin
              state    <= SETUP;
              alu_inst <= NOP_WORD;
            end
          end
        end
        SETUP: begin
          state    <= ISSUE;
          alu_inst <= inst_q;
          cnt      <= CNT_INIT;
`ifdef ALU_ISSUE_FASTISSUE_EN
          loaded   <= 1'b0;
`endif
        end
        ISSUE: begin
          if (cnt == 4'd0) state <= CAPTURE;
          else             cnt   <= cnt - 4'd1;
        end
        CAPTURE: begin
          if (wr_a) reg_A <= alu_reg_A_res;
          if (wr_b) reg_B <= alu_reg_B_res;
          if (wr_f) begin
            Z <= alu_Z_res;
            N <= alu_N_res;
            C <= alu_C_res;
          end
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU model.
// Two instances: settle 1 (main) and settle 4 (reset abort).
module tb_alu_issue_ctrl;

`ifdef ALU_ISSUE_FASTISSUE_EN
  localparam int FAST_LAT = 3;
`else
  localparam int FAST_LAT = 4;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst2 = 1'b1;
  logic [15:0] inst_in = '0;
  logic inst_valid = 1'b0;
  logic load_en = 1'b0;
  logic load_sel = 1'b0;
  logic [15:0] load_data = '0;

  logic inst_ready, busy, done;
  logic [15:0] alu_inst, alu_a, alu_b, a_res, b_res;
  logic alu_z, alu_n, alu_c, z_res, n_res, c_res;
  logic [15:0] reg_A, reg_B;
  logic Z, N, C;

  logic inst_ready2, busy2, done2;
  logic [15:0] alu_inst2, alu_a2, alu_b2, a_res2, b_res2;
  logic alu_z2, alu_n2, alu_c2, z_res2, n_res2, c_res2;
  logic [15:0] reg_A2, reg_B2;
  logic Z2, N2, C2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [34:0] alu_f(
    input logic [15:0] i,
    input logic [15:0] a,
    input logic [15:0] b,
    input logic z, n, c
  );
    logic [16:0] s;
    logic [15:0] ra, rb;
    logic rz, rn, rc;
    logic fl;
    ra = a; rb = b; rz = z; rn = n; rc = c;
    s = '0; fl = 1'b0;
    case (i[15:12])
      4'h2: begin
        if (i[11]) begin
          s = {1'b0, b} + 17'd1; rb = s[15:0];
        end else begin
          s = {1'b0, a} + 17'd1; ra = s[15:0];
        end
        fl = 1'b1;
      end
      4'h4: begin
        s = {1'b0, a} + {1'b0, b}; ra = s[15:0]; fl = 1'b1;
      end
      4'h5: begin
        s = {1'b0, a} - {1'b0, b}; ra = s[15:0]; fl = 1'b1;
      end
      4'hB: begin
        ra = b; rb = a;
      end
      4'hC: begin
        s = {1'b0, a} - {1'b0, b}; ra = ~a; fl = 1'b1;
      end
      default: ;
    endcase
    if (fl) begin
      rz = (s[15:0] == 16'h0000);
      rn = s[15];
      rc = s[16];
    end
    return {ra, rb, rz, rn, rc};
  endfunction

  assign {a_res, b_res, z_res, n_res, c_res} =
    alu_f(alu_inst, alu_a, alu_b, alu_z, alu_n, alu_c);
  assign {a_res2, b_res2, z_res2, n_res2, c_res2} =
    alu_f(alu_inst2, alu_a2, alu_b2, alu_z2, alu_n2, alu_c2);

  alu_issue_ctrl #(.NOP_OPCODE(4'b0000), .SETTLE_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .inst_in(inst_in), .inst_valid(inst_valid),
    .inst_ready(inst_ready),
    .load_en(load_en), .load_sel(load_sel), .load_data(load_data),
    .alu_inst(alu_inst), .alu_reg_A(alu_a), .alu_reg_B(alu_b),
    .alu_Z(alu_z), .alu_N(alu_n), .alu_C(alu_c),
    .alu_reg_A_res(a_res), .alu_reg_B_res(b_res),
    .alu_Z_res(z_res), .alu_N_res(n_res), .alu_C_res(c_res),
    .reg_A(reg_A), .reg_B(reg_B), .Z(Z), .N(N), .C(C),
    .busy(busy), .done(done)
  );

  alu_issue_ctrl #(.NOP_OPCODE(4'b0000), .SETTLE_CYCLES(4)) dut2 (
    .clk(clk), .rst(rst2),
    .inst_in(inst_in), .inst_valid(inst_valid),
    .inst_ready(inst_ready2),
    .load_en(load_en), .load_sel(load_sel), .load_data(load_data),
    .alu_inst(alu_inst2), .alu_reg_A(alu_a2), .alu_reg_B(alu_b2),
    .alu_Z(alu_z2), .alu_N(alu_n2), .alu_C(alu_c2),
    .alu_reg_A_res(a_res2), .alu_reg_B_res(b_res2),
    .alu_Z_res(z_res2), .alu_N_res(n_res2), .alu_C_res(c_res2),
    .reg_A(reg_A2), .reg_B(reg_B2), .Z(Z2), .N(N2), .C(C2),
    .busy(busy2), .done(done2)
  );

  task automatic load(input logic sel, input logic [15:0] d);
    load_en = 1'b1; load_sel = sel; load_data = d;
    @(negedge clk);
    load_en = 1'b0;
  endtask

  // called at a negedge with dut idle; returns at the done negedge
  task automatic run(input logic [15:0] i, output int lat,
                     output logic [15:0] first);
    inst_in = i; inst_valid = 1'b1;
    @(posedge clk);
    #1 inst_valid = 1'b0;
    lat = 0; first = 16'hxxxx;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 1) first = alu_inst;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({reg_A, reg_B} !== 32'h0) begin
      errors++;
      $display("FAIL reset_regs got %h %h want 0 0", reg_A, reg_B);
    end
    checks++;
    if ({Z, N, C, busy, done} !== 5'b00000) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000",
               {Z, N, C, busy, done});
    end
    checks++;
    if (alu_inst !== 16'h0000 || inst_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_io got inst %h rdy %b want 0000 1",
               alu_inst, inst_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_add;
    int lat;
    logic [15:0] f;
    load(1'b0, 16'h0003);
    load(1'b1, 16'h0005);
    run(16'h4000, lat, f);
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL add_latency got %0d want 4", lat);
    end
    checks++;
    if (reg_A !== 16'h0008 || reg_B !== 16'h0005) begin
      errors++;
      $display("FAIL add_regs got %h %h want 0008 0005", reg_A, reg_B);
    end
    checks++;
    if (Z !== 1'b0 || N !== 1'b0 || inst_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_flags got Z%b N%b rdy%b want 0 0 1",
               Z, N, inst_ready);
    end
  endtask

  task automatic test_repeat_inc;
    int lat;
    logic [15:0] f;
    load(1'b0, 16'h0000);
    run(16'h2001, lat, f);
    checks++;
    if (reg_A !== 16'h0001 || f !== 16'h0000) begin
      errors++;
      $display("FAIL inc1 got A %h nop %h want 0001 0000", reg_A, f);
    end
    run(16'h2001, lat, f);
    checks++;
    if (reg_A !== 16'h0002 || f !== 16'h0000) begin
      errors++;
      $display("FAIL inc2 got A %h nop %h want 0002 0000", reg_A, f);
    end
    checks++;
    if (lat !== 4) begin
      errors++;
      $display("FAIL inc2_latency got %0d want 4", lat);
    end
    run(16'h2801, lat, f);
    checks++;
    if (reg_A !== 16'h0002 || reg_B !== 16'h0006) begin
      errors++;
      $display("FAIL incb got %h %h want 0002 0006", reg_A, reg_B);
    end
  endtask

  task automatic test_mask;
    int lat;
    logic [15:0] f;
    load(1'b0, 16'h1234);
    load(1'b1, 16'h1234);
    run(16'hC000, lat, f);
    checks++;
    if (Z !== 1'b1) begin
      errors++;
      $display("FAIL cmp_z got %b want 1", Z);
    end
    checks++;
    if (reg_A !== 16'h1234 || reg_B !== 16'h1234) begin
      errors++;
      $display("FAIL cmp_mask got %h %h want 1234 1234", reg_A, reg_B);
    end
  endtask

  task automatic test_load_priority;
    int lat;
    load(1'b1, 16'h0055);
    load_en = 1'b1; load_sel = 1'b0; load_data = 16'h0007;
    inst_in = 16'h2001; inst_valid = 1'b1;
    #1;
    checks++;
    if (inst_ready !== 1'b0) begin
      errors++;
      $display("FAIL prio_ready got %b want 0", inst_ready);
    end
    @(posedge clk);
    #1 load_en = 1'b0;
    @(negedge clk);
    checks++;
    if (reg_A !== 16'h0007 || busy !== 1'b0) begin
      errors++;
      $display("FAIL prio_load got A %h busy %b want 0007 0",
               reg_A, busy);
    end
    @(negedge clk);
    inst_valid = 1'b0;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL prio_accept got busy %b want 1", busy);
    end
    load_en = 1'b1; load_sel = 1'b1; load_data = 16'hFFFF;
    @(negedge clk);
    load_en = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (lat == 0 || reg_A !== 16'h0008 || reg_B !== 16'h0055) begin
      errors++;
      $display("FAIL busy_load got done %0d A %h B %h want A 0008 B 0055",
               lat, reg_A, reg_B);
    end
  endtask

  task automatic test_fast_issue;
    int lat;
    logic [15:0] f;
    load(1'b0, 16'h000A);
    load(1'b1, 16'h0003);
    run(16'h4000, lat, f);
    checks++;
    if (lat !== 4 || reg_A !== 16'h000D) begin
      errors++;
      $display("FAIL fast_add got lat %0d A %h want 4 000D", lat, reg_A);
    end
    run(16'h5000, lat, f);
    checks++;
    if (lat !== FAST_LAT || reg_A !== 16'h000A) begin
      errors++;
      $display("FAIL fast_sub got lat %0d A %h want %0d 000A",
               lat, reg_A, FAST_LAT);
    end
    run(16'hF000, lat, f);
    checks++;
    if (lat !== FAST_LAT || reg_A !== 16'h000A || reg_B !== 16'h0003) begin
      errors++;
      $display("FAIL nop_op got lat %0d A %h B %h want %0d 000A 0003",
               lat, reg_A, reg_B, FAST_LAT);
    end
  endtask

  task automatic test_reset_abort;
    int lat;
    int seen;
    rst = 1'b1;
    rst2 = 1'b0;
    @(negedge clk);
    load(1'b0, 16'h0001);
    load(1'b1, 16'h0002);
    inst_in = 16'h4000; inst_valid = 1'b1;
    @(posedge clk);
    #1 inst_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy2 !== 1'b1 || alu_inst2 !== 16'h4000) begin
      errors++;
      $display("FAIL abort_mid got busy %b inst %h want 1 4000",
               busy2, alu_inst2);
    end
    rst2 = 1'b1;
    @(negedge clk);
    rst2 = 1'b0;
    checks++;
    if ({reg_A2, reg_B2} !== 32'h0 || {Z2, N2, C2} !== 3'b000) begin
      errors++;
      $display("FAIL abort_regs got %h %h %b want 0 0 000",
               reg_A2, reg_B2, {Z2, N2, C2});
    end
    checks++;
    if (alu_inst2 !== 16'h0000 || inst_ready2 !== 1'b1 ||
        busy2 !== 1'b0 || done2 !== 1'b0) begin
      errors++;
      $display("FAIL abort_io got %h rdy%b busy%b done%b want 0000 1 0 0",
               alu_inst2, inst_ready2, busy2, done2);
    end
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done2 === 1'b1) seen++;
    end
    checks++;
    if (seen != 0 || reg_A2 !== 16'h0000) begin
      errors++;
      $display("FAIL abort_done got %0d pulses A %h want 0 0000",
               seen, reg_A2);
    end
    load(1'b0, 16'h0001);
    load(1'b1, 16'h0002);
    inst_in = 16'hB000; inst_valid = 1'b1;
    @(posedge clk);
    #1 inst_valid = 1'b0;
    lat = 0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (done2) begin
        lat = k;
        break;
      end
    end
    checks++;
    if (lat !== 7) begin
      errors++;
      $display("FAIL exch_latency got %0d want 7", lat);
    end
    checks++;
    if (reg_A2 !== 16'h0002 || reg_B2 !== 16'h0001 ||
        {Z2, N2, C2} !== 3'b000) begin
      errors++;
      $display("FAIL exch got %h %h %b want 0002 0001 000",
               reg_A2, reg_B2, {Z2, N2, C2});
    end
  endtask

  initial begin
    test_reset;
    test_add;
    test_repeat_inc;
    test_mask;
    test_load_priority;
    test_fast_issue;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential execute-stage controller that sits on the opposite side of the S-Machine ALU. It owns the architectural A and B registers and the Z/N/C status flags, and accepts one instruction at a time through a valid/ready handshake. It drives the ALU's operand, flag and instruction inputs in a fixed order so the combinational ALU re-evaluates with stable operands, then writes back the ALU results under a per-opcode write mask.

## Interface
- `NOP_OPCODE`, default 4'b0000: opcode driven on `alu_inst[15:12]` during SETUP; the low 12 bits are 0.
- `SETTLE_CYCLES`, default 1: cycles `alu_inst` is held before capture. Legal range 1..15.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `inst_in` in 16: instruction word.
- `inst_valid` in 1: `inst_in` is valid.
- `inst_ready` out 1: the block can accept an instruction this cycle.
- `load_en` in 1: direct register write request.
- `load_sel` in 1: 0 = write A, 1 = write B.
- `load_data` in 16: value for the direct write.
- `alu_inst` out 16: drives the ALU instruction input.
- `alu_reg_A`, `alu_reg_B` out 16 each: drive the ALU operand inputs; always equal to `reg_A` and `reg_B`.
- `alu_Z`, `alu_N`, `alu_C` out 1 each: drive the ALU flag inputs; always equal to the stored flags.
- `alu_reg_A_res`, `alu_reg_B_res` in 16 each: ALU result outputs.
- `alu_Z_res`, `alu_N_res`, `alu_C_res` in 1 each: ALU flag outputs.
- `reg_A`, `reg_B` out 16 each: architectural registers.
- `Z`, `N`, `C` out 1 each: architectural status flags.
- `busy` out 1: high whenever the state is not IDLE.
- `done` out 1: one-cycle pulse after writeback.

## Operation
- States and transitions:
  - IDLE to SETUP on accept (`inst_valid & inst_ready`).
  - SETUP to ISSUE after 1 cycle.
  - ISSUE to CAPTURE after `SETTLE_CYCLES` cycles, counted by a 4-bit down-counter.
  - CAPTURE to IDLE after 1 cycle.
- The accepted instruction is latched into an internal register; `inst_in` may change after acceptance.
- SETUP: `alu_inst` = {NOP_OPCODE, 12'h000}. This forces a change on `alu_inst`, so the ALU re-evaluates even when the same instruction is issued twice in a row.
- ISSUE: `alu_inst` = latched instruction.
- CAPTURE: writeback on the edge that leaves CAPTURE, using an opcode mask (op = inst[15:12]):
  - A ← `alu_reg_A_res` for op 0010 with inst[11]=0, and for op 0100, 0101, 0110, 0111, 1000, 1001, 1011.
  - B ← `alu_reg_B_res` for op 0010 with inst[11]=1, and for op 1010, 1011.
  - Z/N/C ← ALU flags for op 0010 and for op 0100 through 1110.
  - op 0000, 0001, 0011, 1111: no writes; `done` still pulses.
- In IDLE, `alu_inst` holds the last issued instruction; it is {NOP_OPCODE, 0} after reset.
- `inst_ready` = (state == IDLE) & ~`load_en`. A direct load has priority over accepting an instruction.
- Direct load: applied only in IDLE. In IDLE, `load_en` writes `load_data` into A or B on the next edge. `load_en` outside IDLE is ignored; no error is reported.
- All arithmetic is done by the ALU. This block does no width extension or modification of any value.

## Timing
- Reset values: `reg_A` = `reg_B` = 16'h0000; Z = N = C = 0; `alu_inst` = {NOP_OPCODE, 12'h000}; `inst_ready` = 1; `busy` = 0; `done` = 0; state IDLE.
- Reset mid-operation: abort with no writeback and no `done`. Everything returns to reset values on that edge.
- Latency (accept edge = edge 0):
  - SETUP occupies cycle 1.
  - ISSUE occupies cycles 2..1+S, where S = `SETTLE_CYCLES`.
  - CAPTURE occupies cycle 2+S.
  - New register and flag values, `done` = 1 and `inst_ready` = 1 all appear in cycle 3+S.
  - With S = 1, results are visible 4 cycles after the accept edge.
- Throughput: a new instruction may be accepted in the same cycle `done` is high. The issue interval is S+3 cycles.
- `done` is registered and high for exactly 1 cycle per accepted instruction.
- `busy` is high from cycle 1 through cycle 2+S.

## Configuration
- `ALU_ISSUE_FASTISSUE_EN` defined: SETUP is skipped (IDLE goes directly to ISSUE) when both hold:
  - the accepted instruction differs from the current `alu_inst`, and
  - no direct load has occurred since the last issue.
  
  Latency then becomes S+2 cycles. Otherwise SETUP is used as normal.
- `ALU_ISSUE_FASTISSUE_EN` undefined: SETUP is always used.

## Test plan
- ADD: load A = 16'h0003, B = 16'h0005, issue 16'h4000. Required: `done` in cycle 4 after the accept edge; A = 16'h0008; B unchanged; Z = 0, N = 0.
- Repeated instruction: issue INC A, 16'h2001, twice back-to-back with A = 0. Required: A = 1, then A = 2; `alu_inst` shows 16'h0000 for 1 cycle before each issue.
- Mask check: A = 16'h1234, B = 16'h1234, issue CMP 16'hC000. Required: Z = 1; A and B unchanged, even though `alu_reg_A_res` is stale.
- Load priority: hold `inst_valid` = 1 and `load_en` = 1 together in IDLE. Required: `inst_ready` = 0, the load lands, and the instruction is accepted on the next cycle. `load_en` pulsed while `busy` = 1 must leave A and B unchanged.
- Reset mid-ISSUE with `SETTLE_CYCLES` = 4, then EXCH 16'hB000 with A = 1, B = 2. Required: after reset, all outputs at reset values and no `done`; the EXCH then yields A = 2, B = 1, flags unchanged.
- Fast issue with `ALU_ISSUE_FASTISSUE_EN` defined: issue ADD then SUB. Required: the SUB `done` arrives 3 cycles after its accept edge.
